// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / fetch-control stage (package fetch_pkg).
package fetch_pkg;

    localparam int PC_W              = 32;
    localparam int DEFAULT_LAST_ADDR = 16;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic {
        REDIR_BRANCH = 1'b0,
        REDIR_JUMP   = 1'b1
    } redir_sel_e;

    function automatic logic addr_in_range(input pc_t addr, input pc_t last_addr);
        return addr <= last_addr;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/fetch bundle between the pipeline controller (master) and the fetch unit (slave).
interface pc_fetch_unit_if #(
    parameter int OFFSET_W = 16
);
    logic                stall_i;
    logic                redirect_i;
    logic                redirect_sel_i;
    logic [OFFSET_W-1:0] branch_offset_i;
    logic [31:0]         jump_target_i;

    logic [31:0]         PC;
    logic [31:0]         fetch_pc_o;
    logic                fetch_valid_o;
    logic                halted_o;
    logic [31:0]         fetch_count_o;
    logic [31:0]         redirect_count_o;

    modport master (
        output stall_i, redirect_i, redirect_sel_i, branch_offset_i, jump_target_i,
        input  PC, fetch_pc_o, fetch_valid_o, halted_o, fetch_count_o, redirect_count_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_sel_i, branch_offset_i, jump_target_i,
        output PC, fetch_pc_o, fetch_valid_o, halted_o, fetch_count_o, redirect_count_o
    );
endinterface

// File: rtl/pc_fetch_unit_target_calc.sv
// Combinational redirect target: relative branch from the current fetch PC, or absolute jump.
module fetch_target_calc
    import fetch_pkg::*;
#(
    parameter int OFFSET_W = 16
) (
    input  pc_t                 fetch_pc,
    input  logic [OFFSET_W-1:0] branch_offset,
    input  pc_t                 jump_target,
    input  redir_sel_e          redirect_sel,
    output pc_t                 target
);
    pc_t offset_ext;
    pc_t branch_target;

    // Sign-extend, then let the 32-bit add wrap so negative results land far out of range.
    assign offset_ext    = PC_W'(signed'(branch_offset));
    assign branch_target = fetch_pc + pc_t'(1) + offset_ext;
    assign target        = (redirect_sel == REDIR_JUMP) ? jump_target : branch_target;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and fetch control in front of a 1-cycle synchronous instruction memory.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int RESET_PC  = 0,
    parameter int LAST_ADDR = DEFAULT_LAST_ADDR,
    parameter int OFFSET_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_unit_if.slave   bus
);
    localparam pc_t RESET_ADDR = pc_t'(RESET_PC);
    localparam pc_t LAST       = pc_t'(LAST_ADDR);

    pc_t  pc_q;
    pc_t  fetch_pc_q;
    logic fetch_valid_q;
    logic halted_q;

    pc_t  target;
    pc_t  addr;
    logic addr_ok;
    logic hold;
    logic take_fetch;

    fetch_target_calc #(.OFFSET_W(OFFSET_W)) u_target_calc (
        .fetch_pc      (fetch_pc_q),
        .branch_offset (bus.branch_offset_i),
        .jump_target   (bus.jump_target_i),
        .redirect_sel  (redir_sel_e'(bus.redirect_sel_i)),
        .target        (target)
    );

    always_comb begin
        // NOTE: default assignment first so every path drives addr and no latch is inferred.
        addr = pc_q;
        if (bus.redirect_i) begin
            addr = target;
        end else if (bus.stall_i && fetch_valid_q) begin
            addr = fetch_pc_q;
        end
    end

    assign addr_ok    = addr_in_range(addr, LAST);
    assign hold       = !bus.redirect_i && (halted_q || bus.stall_i);
    assign take_fetch = !hold && addr_ok;

    // Memory must see the reset PC the moment reset asserts, not just after the next edge.
    assign bus.PC = rst_n ? addr : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_ADDR;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else if (!hold) begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            if (addr_ok) begin
                fetch_pc_q    <= addr;
                fetch_valid_q <= 1'b1;
                pc_q          <= addr + pc_t'(1);
                halted_q      <= 1'b0;
            end else begin
                fetch_valid_q <= 1'b0;
                halted_q      <= 1'b1;
                pc_q          <= addr;
            end
        end
    end

    assign bus.fetch_pc_o    = fetch_pc_q;
    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.halted_o      = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redir_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (take_fetch && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bus.redirect_i && !halted_q && (redir_cnt_q != '1)) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign bus.fetch_count_o    = fetch_cnt_q;
    assign bus.redirect_count_o = redir_cnt_q;
`else
    logic unused_take_fetch;
    assign unused_take_fetch    = take_fetch;
    assign bus.fetch_count_o    = '0;
    assign bus.redirect_count_o = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit with a 17-word synchronous instruction memory model.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] fpc;
        logic        valid;
        logic        halted;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] out_instruction;
    int          compared   = 0;
    int          mismatched = 0;
    exp_t        sb[$];

    pc_fetch_unit_if #(.OFFSET_W(16)) bus ();

    pc_fetch_unit #(.RESET_PC(0), .LAST_ADDR(16), .OFFSET_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 + (a * 32'h0000_0101);
    endfunction

    // Synchronous memory: no enable, ignores out-of-range addresses and keeps its last word.
    always @(posedge clk) begin
        if (bus.PC <= 32'd16) out_instruction <= mem_word(bus.PC);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},     bus.PC,                   32'd0);
        check({tag, "_fpc"},    bus.fetch_pc_o,           32'd0);
        check({tag, "_valid"},  {31'd0, bus.fetch_valid_o}, 32'd0);
        check({tag, "_halted"}, {31'd0, bus.halted_o},    32'd0);
        check({tag, "_fcnt"},   bus.fetch_count_o,        32'd0);
        check({tag, "_rcnt"},   bus.redirect_count_o,     32'd0);
    endtask

    // Drive one cycle of stimulus, check the combinational PC, queue the post-edge expectation.
    task automatic step(input logic st, input logic rd, input logic sel,
                        input logic [15:0] off, input logic [31:0] tgt,
                        input logic [31:0] exp_pc, input logic [31:0] exp_fpc,
                        input logic exp_v, input logic exp_h, input string tag);
        exp_t e;
        @(negedge clk);
        bus.stall_i         = st;
        bus.redirect_i      = rd;
        bus.redirect_sel_i  = sel;
        bus.branch_offset_i = off;
        bus.jump_target_i   = tgt;
        #1;
        check({tag, "_PC"}, bus.PC, exp_pc);
        sb.push_back('{fpc: exp_fpc, valid: exp_v, halted: exp_h, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_fpc"},    bus.fetch_pc_o,             e.fpc);
        check({e.tag, "_valid"},  {31'd0, bus.fetch_valid_o}, {31'd0, e.valid});
        check({e.tag, "_halted"}, {31'd0, bus.halted_o},      {31'd0, e.halted});
        if (e.valid) check({e.tag, "_instr"}, out_instruction, mem_word(e.fpc));
    endtask

    task automatic seq(input int a, input string tag);
        step(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'(a), 32'(a), 1'b1, 1'b0, tag);
    endtask

    initial begin
        // Reset with a jump pending: PC must still show the reset PC.
        rst_n               = 1'b0;
        bus.stall_i         = 1'b0;
        bus.redirect_i      = 1'b1;
        bus.redirect_sel_i  = 1'b1;
        bus.branch_offset_i = 16'd0;
        bus.jump_target_i   = 32'd7;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        bus.redirect_i = 1'b0;
        rst_n          = 1'b1;

        for (int i = 0; i <= 5; i++) seq(i, "seq_a");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 32'd5, 32'd5, 1'b1, 1'b0, "stall");
        seq(6, "stall_release");

        step(1'b0, 1'b1, 1'b1, 16'd0, 32'd4, 32'd4, 32'd4, 1'b1, 1'b0, "jump4");
        step(1'b0, 1'b1, 1'b0, 16'hFFFD, 32'd0, 32'd2, 32'd2, 1'b1, 1'b0, "branch_m3");
        seq(3, "after_branch");
        seq(4, "back_to4");
        step(1'b1, 1'b1, 1'b0, 16'hFFFD, 32'd0, 32'd2, 32'd2, 1'b1, 1'b0, "branch_m3_stall");
        seq(3, "after_branch_stall");

        step(1'b0, 1'b1, 1'b1, 16'd0, 32'd20, 32'd20, 32'd3, 1'b0, 1'b1, "jump20");
        step(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd20, 32'd3, 1'b0, 1'b1, "halt_idle");
        step(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 32'd20, 32'd3, 1'b0, 1'b1, "halt_stall");
        step(1'b0, 1'b1, 1'b1, 16'd0, 32'd7, 32'd7, 32'd7, 1'b1, 1'b0, "jump7");

        for (int i = 8; i <= 16; i++) seq(i, "seq_b");
        step(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd17, 32'd16, 1'b0, 1'b1, "end_of_prog");
        step(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd17, 32'd16, 1'b0, 1'b1, "end_hold");
        step(1'b0, 1'b1, 1'b0, 16'hFFEC, 32'd0, 32'hFFFF_FFFD, 32'd16, 1'b0, 1'b1, "neg_wrap");
        step(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'hFFFF_FFFD, 32'd16, 1'b0, 1'b1, "neg_hold");
        step(1'b0, 1'b1, 1'b1, 16'd0, 32'd16, 32'd16, 32'd16, 1'b1, 1'b0, "jump_last");
        step(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd17, 32'd16, 1'b0, 1'b1, "past_last");
        step(1'b0, 1'b1, 1'b1, 16'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, "jump0");
        for (int i = 1; i <= 9; i++) seq(i, "seq_c");

        // Mid-stream reset: outputs must clear with no clock edge.
        @(negedge clk);
        bus.redirect_i     = 1'b1;
        bus.redirect_sel_i = 1'b1;
        bus.jump_target_i  = 32'd12;
        rst_n              = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        bus.redirect_i = 1'b0;
        rst_n          = 1'b1;

        for (int i = 0; i <= 8; i++) seq(i, "restart");
        step(1'b0, 1'b1, 1'b1, 16'd0, 32'd3, 32'd3, 32'd3, 1'b1, 1'b0, "count_jump");
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", bus.fetch_count_o, 32'd10);
        check("redirect_count", bus.redirect_count_o, 32'd1);
`else
        check("fetch_count", bus.fetch_count_o, 32'd0);
        check("redirect_count", bus.redirect_count_o, 32'd0);
`endif
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
